// File: rtl/reuleaux_pkg.sv
// Shared constants and types for the Reuleaux triangle sequencer.
package reuleaux_pkg;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  // sqrt(3)/6 and sqrt(3)/3 in Q.7 fixed point
  localparam int K_SQ3_6 = 37;
  localparam int K_SQ3_3 = 74;
  localparam int K_SHIFT = 7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CALC    = 3'd1;
  localparam logic [2:0] S_CLEAR   = 3'd2;
  localparam logic [2:0] S_LAUNCH  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  // On-screen vertex; only meaningful once the geometry passed the range check
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } vertex_t;

endpackage

// File: rtl/reuleaux_geom.sv
// Combinational triangle vertex calculation and off-screen detection.
module reuleaux_geom
  import reuleaux_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input  logic [7:0] cx,
  input  logic [6:0] cy,
  input  logic [7:0] d,
  output vertex_t    vl,
  output vertex_t    vr,
  output vertex_t    vt,
  output logic       off_screen
);

  localparam logic signed [9:0] X_MAX = 10'(SCR_W - 1);
  localparam logic signed [9:0] Y_MAX = 10'(SCR_H - 1);

  logic [15:0]       prod_b;
  logic [15:0]       prod_t;
  logic signed [9:0] h, dyb, dyt, x0, y0, lx, rx, yb, yt;

  function automatic logic out_of(input logic signed [9:0] v, input logic signed [9:0] vmax);
    return v[9] || (v > vmax);
  endfunction

  always_comb begin
    prod_b = 16'(d) * 16'(K_SQ3_6);
    prod_t = 16'(d) * 16'(K_SQ3_3);
    h      = 10'(d >> 1);
    dyb    = 10'(prod_b >> K_SHIFT);
    dyt    = 10'(prod_t >> K_SHIFT);
    x0     = 10'(cx);
    y0     = 10'(cy);
    lx     = x0 - h;
    rx     = x0 + h;
    yb     = y0 + dyb;
    yt     = y0 - dyt;
    vl     = '{x: lx[7:0], y: yb[7:0]};
    vr     = '{x: rx[7:0], y: yb[7:0]};
    vt     = '{x: x0[7:0], y: yt[7:0]};
    off_screen = out_of(lx, X_MAX) || out_of(rx, X_MAX) || out_of(x0, X_MAX) ||
                 out_of(yb, Y_MAX) || out_of(yt, Y_MAX);
  end

endmodule

// File: rtl/reuleaux_sched.sv
// Draws a Reuleaux triangle by running one arc engine from each vertex,
// clipping every arc to its edge, with an optional full-screen clear first.
module reuleaux_sched
  import reuleaux_pkg::*;
#(
  parameter int CLEAR_EN = 1,
  parameter int SCR_W    = SCR_W_DEF,
  parameter int SCR_H    = SCR_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  output logic       err,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  output logic       arc_start,
  input  logic       arc_finished,
  output logic [7:0] arc_cx,
  output logic [7:0] arc_cy,
  output logic [7:0] arc_radius,
  output logic [2:0] arc_colour,
  input  logic [7:0] arc_x,
  input  logic [6:0] arc_y,
  input  logic       arc_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);

  logic [2:0] state;
  logic [1:0] k;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic [7:0] cx_q, d_q;
  logic [6:0] cy_q;
  logic [2:0] col_q;
  vertex_t    vl_q, vr_q, vt_q, sel_v;
  vertex_t    geo_l, geo_r, geo_t;
  logic       geo_off;
  logic       clip_ok;

  reuleaux_geom #(.SCR_W(SCR_W), .SCR_H(SCR_H)) u_geom (
    .cx(cx_q), .cy(cy_q), .d(d_q),
    .vl(geo_l), .vr(geo_r), .vt(geo_t), .off_screen(geo_off)
  );

  // Job inputs and vertices are captured once and held for the whole job
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cx_q  <= centre_x;
      cy_q  <= centre_y;
      d_q   <= diameter;
      col_q <= colour;
    end
    if (state == S_CALC) begin
      vl_q <= geo_l;
      vr_q <= geo_r;
      vt_q <= geo_t;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= 2'd0;
      err   <= 1'b0;
      clr_x <= 8'd0;
      clr_y <= 7'd0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_CALC;
        S_CALC: begin
          k <= 2'd0;
          if (geo_off) begin
            err   <= 1'b1;
            state <= S_FIN;
          end else if (CLEAR_EN != 0) state <= S_CLEAR;
          else state <= S_LAUNCH;
        end
        S_CLEAR: begin
          if (clr_x == X_LAST) begin
            clr_x <= 8'd0;
            if (clr_y == Y_LAST) begin
              clr_y <= 7'd0;
              state <= S_LAUNCH;
            end else clr_y <= clr_y + 7'd1;
          end else clr_x <= clr_x + 8'd1;
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT:   if (arc_finished) state <= S_RELEASE;
        // Engine must drop finished before the next job may start
        S_RELEASE: if (!arc_finished) begin
          if (k == 2'd2) state <= S_FIN;
          else begin
            k     <= k + 2'd1;
            state <= S_LAUNCH;
          end
        end
        S_FIN: if (!start) begin
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Job 0 draws the bottom edge from the top vertex, jobs 1/2 the sides
  always_comb begin
    case (k)
      2'd1:    sel_v = vl_q;
      2'd2:    sel_v = vr_q;
      default: sel_v = vt_q;
    endcase
  end

  assign arc_cx     = sel_v.x;
  assign arc_cy     = sel_v.y;
  assign arc_radius = d_q;
  assign arc_colour = col_q;
  assign arc_start  = (state == S_LAUNCH) || (state == S_WAIT);
  assign done       = (state == S_FIN);

  always_comb begin
    case (k)
      2'd0:    clip_ok = ({1'b0, arc_y} >= vl_q.y);
      2'd1:    clip_ok = (arc_x >= vt_q.x) && ({1'b0, arc_y} <= vl_q.y);
      2'd2:    clip_ok = (arc_x <= vt_q.x) && ({1'b0, arc_y} <= vl_q.y);
      default: clip_ok = 1'b0;
    endcase
  end

  always_comb begin
    vga_x      = arc_x;
    vga_y      = arc_y;
    vga_colour = col_q;
    vga_plot   = 1'b0;
    case (state)
      S_CLEAR: begin
        vga_x      = clr_x;
        vga_y      = clr_y;
        vga_colour = 3'b000;
        vga_plot   = 1'b1;
      end
      S_WAIT:  vga_plot = arc_plot & clip_ok;
      default: ;
    endcase
  end

endmodule
